blft_frame_server: RTL
======================

// Module: blft_frame_server
// PURPOSE
//  Memory-side responder for the bilateral filter core's pixel interfaces.
//  - Read side: answers each filter read address with the pixel from a synchronous source RAM.
//  - Write side: captures each filtered pixel into a destination RAM.
//  - Frames a run with start/busy/done; counts reads and writes for the bench and host.
//  Sits between the 256x256 8-bit image RAMs and the filter core, in the same clk/rst domain.
// PARAMETERS
//  ADDR_W   16  pixel address width ({row[7:0],col[7:0]})
//  DATA_W   8   pixel width
//  RD_LAT   1   source RAM read latency in cycles; legal values 1 or 2
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       reset, asynchronous, active-high
//  start          in   1       single-cycle frame start pulse
//  cfg_gap        in   4       idle cycles inserted after each presented pixel (throttle)
//  busy           out  1       frame in progress
//  done           out  1       frame complete; held high until next accepted start
//  rd_count       out  17      pixels presented this frame (saturates at 131071)
//  wr_count       out  17      pixels written this frame (saturates at 131071)
//  f_in_addr      in   ADDR_W  filter read address
//  f_in_valid     out  1       f_in_data valid for f_in_addr, one-cycle pulse
//  f_in_data      out  DATA_W  pixel for the filter
//  f_out_valid    in   1       filter result valid
//  f_out_addr     in   ADDR_W  result address
//  f_out_data     in   DATA_W  result pixel
//  f_finish       in   1       filter has finished the frame (level)
//  src_rd_en      out  1       source RAM read enable
//  src_addr       out  ADDR_W  source RAM address
//  src_rdata      in   DATA_W  source RAM data, valid RD_LAT cycles after src_rd_en
//  dst_we         out  1       destination RAM write enable
//  dst_addr       out  ADDR_W  destination RAM address
//  dst_wdata      out  DATA_W  destination RAM data
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters 0. Reset mid-frame aborts the frame; no dst write
//   issues after rst is asserted.
//  FSM: IDLE, ISSUE, WAIT, PRESENT, GAP, DONE.
//  - IDLE/DONE --start--> ISSUE. Entering ISSUE from start clears done and both counters and
//    sets busy=1. start is ignored in every other state.
//  - ISSUE: src_rd_en=1 and src_addr=f_in_addr (combinational, this cycle only). f_in_addr is
//    captured into addr_q. Next state is WAIT.
//  - WAIT: lasts RD_LAT-1 cycles; with RD_LAT=1 the FSM passes straight through to PRESENT.
//  - PRESENT: f_in_valid=1 and f_in_data=src_rdata for exactly 1 cycle; rd_count++.
//    Next state is GAP if cfg_gap!=0, else ISSUE.
//  - GAP: count cfg_gap cycles, then go to ISSUE. cfg_gap is sampled on entry to GAP.
//  - Timing: start to first f_in_valid is 1+RD_LAT cycles.
//    Steady-state read period is 1+RD_LAT+cfg_gap cycles.
//  - f_finish=1 in any of ISSUE/WAIT/PRESENT/GAP -> DONE on the next edge. A read in flight is
//    dropped and f_in_valid is not asserted. On entering DONE: busy=0, done=1.
//  - f_in_data holds its last value when f_in_valid=0 (registered).
//  Write side, independent of the read FSM:
//  - Each cycle with f_out_valid=1 and (busy=1, or the FSM is in the cycle it enters DONE)
//    gives a write on the next cycle: dst_we=1, dst_addr=f_out_addr, dst_wdata=f_out_data.
//  - Every such cycle counts as one write; no merging of repeated addresses. wr_count++.
//  - f_out_valid outside busy is ignored: no write, no count.
//  Simultaneous events:
//  - f_finish together with f_out_valid: the write is still captured.
//  - start together with f_finish while IDLE/DONE: start is accepted and f_finish is ignored
//    that cycle. The host must reset the filter before restarting.
//  Counters are 17 bits so a full 65536-pixel frame and overreads are visible without wrap.
// STRUCTURE
//  Shared package blft_pkg:
//  - ADDR_W, DATA_W, IMG_DIM=256
//  - state enum blft_srv_state_t
//  - count width CNT_W=17
//  Sub-module blft_wr_capture: write register and wr_count saturating counter, gated by busy.
//  The read FSM, gap counter and rd_count stay in the top level.
// TESTING
//  1. RD_LAT=1, cfg_gap=0, src[0x0000]=0x5A, f_in_addr=0, pulse start -> src_rd_en@cyc1,
//     f_in_valid=1 with 0x5A @cyc2, then period 2.
//  2. RD_LAT=2, cfg_gap=3, 4 reads -> f_in_valid period 6 cycles; rd_count=4;
//     src_addr follows f_in_addr at each ISSUE.
//  3. f_out_valid for 3 cycles with addr 0x0505/0x0605/0x0705, data 0x10/0x20/0x30 ->
//     dst_we 3 cycles, each one cycle later; wr_count=3.
//  4. f_finish asserted during WAIT -> no f_in_valid; next cycle busy=0, done=1;
//     done holds until the next start.
//  5. rst asserted mid-frame with f_out_valid=1 -> all outputs 0 immediately; no dst_we;
//     counters 0; FSM restarts only on a new start.
//  6. Full 256x256 run against the filter core -> wr_count=65536 at done;
//     dst RAM matches the golden image (SNR>=40 dB).

Source files
------------

// File: rtl/blft_pkg.sv
// Shared sizes, state encoding and counter helper for the bilateral filter frame server.
package blft_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int IMG_DIM = 256;
  localparam int CNT_W   = 17;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5
  } blft_srv_state_t;

  // Counters stick at all-ones so overreads stay visible instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/blft_wr_capture.sv
// Destination-RAM write register: one write per accepted filter result, one cycle later.
module blft_wr_capture
  import blft_pkg::*;
#(
  parameter int ADDR_W = blft_pkg::ADDR_W,
  parameter int DATA_W = blft_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_busy,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_count
);

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_count;
  logic              w_take;

  assign w_take = i_valid & i_busy;

  // Results arriving outside a frame are dropped; repeats of an address are not merged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= {ADDR_W{1'b0}};
      r_data  <= {DATA_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_we <= w_take;
      if (w_take) begin
        r_addr <= i_addr;
        r_data <= i_data;
      end else begin
        r_addr <= r_addr;
        r_data <= r_data;
      end
      if (i_clr) begin
        r_count <= {CNT_W{1'b0}};
      end else if (w_take) begin
        r_count <= sat_inc(r_count);
      end else begin
        r_count <= r_count;
      end
    end
  end

  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_count = r_count;

endmodule

// File: rtl/blft_frame_server.sv
// Memory-side responder for the bilateral filter: serves pixel reads from the source RAM,
// captures results into the destination RAM and frames the run with start/busy/done.
module blft_frame_server
  import blft_pkg::*;
#(
  parameter int ADDR_W = blft_pkg::ADDR_W,
  parameter int DATA_W = blft_pkg::DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        cfg_gap,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  input  logic [ADDR_W-1:0] f_in_addr,
  output logic              f_in_valid,
  output logic [DATA_W-1:0] f_in_data,
  input  logic              f_out_valid,
  input  logic [ADDR_W-1:0] f_out_addr,
  input  logic [DATA_W-1:0] f_out_data,
  input  logic              f_finish,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_rdata,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] dst_wdata
);

  blft_srv_state_t   r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_f_in_valid;
  logic [DATA_W-1:0] r_data_hold;
  logic [ADDR_W-1:0] r_addr_q;
  logic [3:0]        r_gap_cnt;
  logic [CNT_W-1:0]  r_rd_count;
  logic              w_start_ok;

  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Read FSM; start outranks f_finish because finish is only honoured while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_f_in_valid <= 1'b0;
      r_data_hold  <= {DATA_W{1'b0}};
      r_addr_q     <= {ADDR_W{1'b0}};
      r_gap_cnt    <= 4'd0;
      r_rd_count   <= {CNT_W{1'b0}};
    end else begin
      r_f_in_valid <= 1'b0;
      if (r_f_in_valid) begin
        r_data_hold <= src_rdata;
        r_rd_count  <= sat_inc(r_rd_count);
      end else begin
        r_data_hold <= r_data_hold;
      end
      if (w_start_ok) begin
        r_state    <= S_ISSUE;
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
        r_rd_count <= {CNT_W{1'b0}};
      end else if (r_busy && f_finish) begin
        r_state <= S_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        case (r_state)
          S_ISSUE: begin
            r_addr_q <= f_in_addr;
            if (RD_LAT == 1) begin
              r_state      <= S_PRESENT;
              r_f_in_valid <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            r_state      <= S_PRESENT;
            r_f_in_valid <= 1'b1;
          end
          S_PRESENT: begin
            if (cfg_gap != 4'd0) begin
              r_state   <= S_GAP;
              r_gap_cnt <= cfg_gap - 4'd1;
            end else begin
              r_state <= S_ISSUE;
            end
          end
          S_GAP: begin
            if (r_gap_cnt == 4'd0) begin
              r_state <= S_ISSUE;
            end else begin
              r_gap_cnt <= r_gap_cnt - 4'd1;
            end
          end
          S_IDLE, S_DONE: begin
            r_state <= r_state;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // The RAM address must be presented in the ISSUE cycle itself, so this path is combinational.
  assign src_rd_en  = (r_state == S_ISSUE);
  assign src_addr   = src_rd_en ? f_in_addr : r_addr_q;
  assign f_in_valid = r_f_in_valid;
  assign f_in_data  = r_f_in_valid ? src_rdata : r_data_hold;
  assign busy       = r_busy;
  assign done       = r_done;
  assign rd_count   = r_rd_count;

  blft_wr_capture #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_capture (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start_ok),
    .i_busy  (r_busy),
    .i_valid (f_out_valid),
    .i_addr  (f_out_addr),
    .i_data  (f_out_data),
    .o_we    (dst_we),
    .o_addr  (dst_addr),
    .o_data  (dst_wdata),
    .o_count (wr_count)
  );

endmodule
